// File: rtl/scan_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
// Imported by the line finder and the sequencer top level.
package scan_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned SEL_W     = 3;

  localparam logic [NUM_LINES-1:0] MASK_ALL = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_sequencer_next_line_finder.sv
// Combinational search for the next unmasked line after the current one.
// In init mode the search starts at line 0 and never reports a wrap.
module next_line_finder
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]     cur_i,
  input  logic [NUM_LINES-1:0] mask_i,
  input  logic                 init_i,
  output logic [SEL_W-1:0]     next_o,
  output logic                 wrap_o,
  output logic                 none_valid_o
);

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] found;

  // Scan base+8 down to base+1 so the nearest unmasked line wins last
  always_comb begin
    base  = init_i ? 3'd7 : cur_i;
    found = cur_i;
    cand  = '0;
    for (int k = NUM_LINES; k >= 1; k--) begin
      cand = base + k[SEL_W-1:0];
      if (!mask_i[cand]) begin
        found = cand;
      end
    end
  end

  // Wrap is a return to a lower-or-equal index outside the initial search
  always_comb begin
    next_o       = found;
    none_valid_o = (mask_i == MASK_ALL);
    wrap_o       = !init_i && !none_valid_o && (found <= cur_i);
  end

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin line sequencer driving a 3-to-8 decoder select and enable.
// Holds each unmasked line for dwell+1 cycles, continuous or one-shot.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_oneshot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel,
  output logic               enable_n,
  output logic               busy,
  output logic               frame,
  output logic               done
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_n_q, en_n_d;
  logic               busy_q, busy_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;
  logic               oneshot_q, oneshot_d;

  logic [SEL_W-1:0]   nxt_idx;
  logic               nxt_wrap;
  logic               nxt_none;

  next_line_finder u_finder (
    .cur_i        (sel_q),
    .mask_i       (mask),
    .init_i       (state_q == IDLE),
    .next_o       (nxt_idx),
    .wrap_o       (nxt_wrap),
    .none_valid_o (nxt_none)
  );

  // State and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      en_n_q    <= en_n_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Next-state: start/stop handling, dwell countdown and line advance
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    en_n_d    = en_n_q;
    busy_d    = busy_q;
    frame_d   = 1'b0;
    done_d    = 1'b0;
    oneshot_d = oneshot_q;
    unique case (state_q)
      IDLE: begin
        en_n_d = 1'b1;
        busy_d = 1'b0;
        if (start && !stop) begin
          if (nxt_none) begin
            done_d = 1'b1;
          end else begin
            state_d   = DWELL;
            sel_d     = nxt_idx;
            cnt_d     = dwell;
            en_n_d    = 1'b0;
            busy_d    = 1'b1;
            oneshot_d = mode_oneshot;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
          en_n_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (nxt_none || (nxt_wrap && oneshot_q)) begin
          state_d = IDLE;
          en_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          sel_d   = nxt_idx;
          cnt_d   = dwell;
          frame_d = nxt_wrap;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sel      = sel_q;
  assign enable_n = en_n_q;
  assign busy     = busy_q;
  assign frame    = frame_q;
  assign done     = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with directed vectors.
// Expectations are queued with a cycle stamp and checked by a monitor.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode_oneshot;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       enable_n;
  logic       busy;
  logic       frame;
  logic       done;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  string tname = "init";
  int   step_no = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mode_oneshot (mode_oneshot),
    .dwell        (dwell),
    .mask         (mask),
    .sel          (sel),
    .enable_n     (enable_n),
    .busy         (busy),
    .frame        (frame),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation stamped for the current cycle
  always @(negedge clk) begin
    logic [6:0] act;
    act = {sel, enable_n, busy, frame, done};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      n_cmp++;
      if (exp_q[0].cyc != cyc || act !== exp_q[0].v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got sel=%0d en_n=%b busy=%b frame=%b done=%b, need sel=%0d en_n=%b busy=%b frame=%b done=%b",
                 exp_q[0].name, cyc, act[6:4], act[3], act[2], act[1], act[0],
                 exp_q[0].v[6:4], exp_q[0].v[3], exp_q[0].v[2],
                 exp_q[0].v[1], exp_q[0].v[0]);
      end
      void'(exp_q.pop_front());
    end
  end

  // Queue the outputs expected after the next edge, then take that edge
  task automatic tick(input int s, input logic en_n, input logic b,
                      input logic f, input logic d);
    exp_t e;
    step_no++;
    e.cyc  = cyc + 1;
    e.v    = {s[2:0], en_n, b, f, d};
    e.name = $sformatf("%s#%0d", tname, step_no);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    mode_oneshot = 1'b0; dwell = 8'd0; mask = 8'h00;
    @(posedge clk);
    #1;
    tname = "reset"; step_no = 0;
    tick(0, 1, 0, 0, 0);
    reset = 1'b0;
    tick(0, 1, 0, 0, 0);

    tname = "cont"; step_no = 0;
    dwell = 8'd1; mask = 8'h00; mode_oneshot = 1'b0; start = 1'b1;
    tick(0, 0, 1, 0, 0);
    start = 1'b0;
    tick(0, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      tick(i, 0, 1, 0, 0);
      tick(i, 0, 1, 0, 0);
    end
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 0, 0);
    stop = 1'b1;
    tick(0, 1, 0, 0, 0);
    stop = 1'b0;

    tname = "oneshot"; step_no = 0;
    mask = 8'b1010_1010; dwell = 8'd0; mode_oneshot = 1'b1; start = 1'b1;
    tick(0, 0, 1, 0, 0);
    start = 1'b0;
    tick(2, 0, 1, 0, 0);
    tick(4, 0, 1, 0, 0);
    tick(6, 0, 1, 0, 0);
    tick(6, 1, 0, 0, 1);
    tick(6, 1, 0, 0, 0);
    mode_oneshot = 1'b0;

    tname = "allmask"; step_no = 0;
    mask = 8'hFF; start = 1'b1;
    tick(6, 1, 0, 0, 1);
    start = 1'b0;
    tick(6, 1, 0, 0, 0);

    tname = "single"; step_no = 0;
    mask = 8'b1111_0111; dwell = 8'd2; start = 1'b1;
    tick(3, 0, 1, 0, 0);
    start = 1'b0;
    tick(3, 0, 1, 0, 0);
    tick(3, 0, 1, 0, 0);
    tick(3, 0, 1, 1, 0);
    tick(3, 0, 1, 0, 0);
    tick(3, 0, 1, 0, 0);
    tick(3, 0, 1, 1, 0);
    stop = 1'b1;
    tick(3, 1, 0, 0, 0);
    stop = 1'b0;

    tname = "stop"; step_no = 0;
    mask = 8'h00; dwell = 8'd0; start = 1'b1;
    tick(0, 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick(i, 0, 1, 0, 0);
    stop = 1'b1;
    tick(5, 1, 0, 0, 0);
    start = 1'b1;
    tick(5, 1, 0, 0, 0);
    start = 1'b0; stop = 1'b0;
    tick(5, 1, 0, 0, 0);

    tname = "livemask"; step_no = 0;
    dwell = 8'd1; start = 1'b1;
    tick(0, 0, 1, 0, 0);
    start = 1'b0;
    tick(0, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(2, 0, 1, 0, 0);
    mask = 8'hFF;
    tick(2, 0, 1, 0, 0);
    tick(2, 1, 0, 0, 1);
    mask = 8'h00;
    tick(2, 1, 0, 0, 0);
    dwell = 8'd0; start = 1'b1;
    tick(0, 0, 1, 0, 0);
    start = 1'b0;

    tname = "rst_mid"; step_no = 0;
    mode_oneshot = 1'b1;
    tick(1, 0, 1, 0, 0);
    tick(2, 0, 1, 0, 0);
    start = 1'b1;
    tick(3, 0, 1, 0, 0);
    start = 1'b0;
    tick(4, 0, 1, 0, 0);
    reset = 1'b1;
    tick(0, 1, 0, 0, 0);
    reset = 1'b0;
    tick(0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 line decoder: generates the 3-bit line select and the active-low decoder enable.
- Steps through the eight output lines in ascending order and holds each line for a programmable dwell time.
- Skips masked lines and runs either continuously or as a single pass (one-shot).
- Used for LED/keypad column scanning and for round-robin strobing of eight peripherals.

Parameters:
- DWELL_W, 8, width of the dwell count. Each line is held for dwell+1 cycles.

Ports:
- clk, input, 1, single system clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, begin a scan. Sampled only in IDLE.
- stop, input, 1, abort the scan. Synchronous.
- mode_oneshot, input, 1, 1 = single pass, 0 = continuous. Sampled at start.
- dwell, input, DWELL_W, hold count per line. Sampled each time a line is loaded.
- mask, input, 8, bit i = 1 skips line i. Sampled live at each line load.
- sel, output, 3, line index to the decoder input. Registered.
- enable_n, output, 1, active-low decoder enable. Registered.
- busy, output, 1, high while scanning.
- frame, output, 1, one-cycle pulse when the scan wraps back to a lower-or-equal index.
- done, output, 1, one-cycle pulse when a scan ends normally.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, applied on a rising edge of clk.
- Reset values:
  - state = IDLE, sel = 0, enable_n = 1, busy = 0, frame = 0, done = 0, dwell counter = 0.
  - Reset asserted mid-scan takes effect at the next edge, overrides everything, and produces no done pulse.
- States:
  - IDLE: enable_n = 1. sel holds its last value.
  - DWELL: enable_n = 0, busy = 1.
- Next-line search from index p: first unmasked index in p+1, p+2, …, p+7 (mod 8), then p itself.
  - Wrap occurs when the found index ≤ p.
  - Initial search at start: the first unmasked index from 0 upward. This never counts as a wrap.
- IDLE → DWELL when start = 1, stop = 0 and mask ≠ 8'hFF.
  - On that edge: sel = first unmasked index, counter = dwell.
  - enable_n goes low on the cycle after start is seen (latency 1).
- IDLE with start = 1 and mask = 8'hFF: stay in IDLE, pulse done for one cycle, busy stays 0.
- DWELL with counter > 0: decrement the counter, keep sel.
- DWELL with counter = 0 (advance), choose the next line with the search above:
  - Continuous mode, or one-shot with no wrap: load the next index and reload counter = dwell. enable_n stays low with no gap cycle.
  - If a wrap occurs in continuous mode: frame = 1 on the same edge the wrapped index appears on sel.
  - One-shot mode with a wrap: go to IDLE; enable_n = 1, busy = 0, done = 1 for one cycle; no frame pulse; sel unchanged.
  - mask = 8'hFF at advance (either mode): go to IDLE with a done pulse.
- stop:
  - Priority is reset > stop > start/advance.
  - In DWELL: next edge → IDLE with enable_n = 1, busy = 0, no done, no frame, sel held.
  - In IDLE: start is ignored in the same cycle.
- start while busy is ignored. A mode_oneshot change mid-scan is ignored.
- Single unmasked line, continuous mode: every advance is a wrap, so frame pulses once per dwell+1 cycles.
- dwell = 0: each line is held exactly 1 cycle, so sel changes every cycle.
- Outputs are glitch-free: sel and enable_n change only at clk edges, on the same edge.

Decomposition:
- Shared package scan_pkg:
  - state encoding: IDLE = 1'b0, DWELL = 1'b1.
  - constants NUM_LINES = 8 and SEL_W = 3.
  - constant MASK_ALL = 8'hFF.
- One combinational sub-module, next_line_finder:
  - inputs: current index, mask, init flag.
  - outputs: next index, wrap, none_valid.
- The top level holds the FSM, the dwell counter and the output registers.

Test Plan:
- Basic continuous scan: reset, then dwell = 1, mask = 0, start pulse.
  - sel = 0,0,1,1,…,7,7,0 with enable_n = 0 from the cycle after start.
  - frame pulses as sel returns to 0; busy = 1 throughout.
- Masked one-shot: mask = 8'b1010_1010, dwell = 0, mode_oneshot = 1, start.
  - sel = 0,2,4,6 on consecutive cycles.
  - On the next edge: enable_n = 1, busy = 0, done = 1 for one cycle; no frame.
- All-masked start and single-line scan:
  - mask = 8'hFF with start → done pulse, busy stays 0, enable_n stays 1.
  - mask = 8'b1111_0111, continuous, dwell = 2 → sel stays 3, frame every 3 cycles.
- Stop mid-scan: assert stop while sel = 5.
  - Next edge: enable_n = 1, busy = 0, no done, sel = 5.
  - start and stop together in IDLE → stays IDLE.
- Live mask change: during a continuous scan at sel = 2, set mask = 8'hFF.
  - At the next advance: IDLE with a done pulse.
  - Restart with mask = 0 → sel begins at 0.
- Reset mid-operation: assert reset while busy at sel = 4.
  - Next edge: all outputs at reset values, no done pulse.
  - start ignored while busy: no change to sel sequence.
